// File: rtl/led_blink_ctrl_if.sv
// Configuration port of led_blink_ctrl: one valid/ready request carrying
// the target channel, its mode and its half-period in ticks.
interface led_blink_ctrl_if;
   logic        valid;
   logic        ready;
   logic [2:0]  ch;
   logic [1:0]  mode;
   logic [15:0] half;

   modport master (output valid, ch, mode, half, input ready);
   modport slave  (input valid, ch, mode, half, output ready);
endinterface

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED blink controller: shared prescaled tick, per-channel OFF/ON/BLINK/ONESHOT.
// Define LED_CTRL_IMMEDIATE_EN to apply configuration without waiting for a tick boundary.
module led_blink_ctrl #(
   parameter int unsigned CLK_HZ  = 100_000_000,
   parameter int unsigned TICK_HZ = 1000,
   parameter int unsigned NUM_LED = 4
) (
   input  logic               i_clk_100MHz,
   input  logic               i_rst,
   led_blink_ctrl_if.slave    cfg,
   output logic [NUM_LED-1:0] o_led,
   output logic               o_tick,
   output logic [NUM_LED-1:0] o_done
);

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_ONESHOT = 2'd3
   } mode_e;

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } cfg_state_e;

   localparam logic [31:0] COUNT_TO = 32'(CLK_HZ / TICK_HZ - 1);

   logic [31:0]        presc_q;
   logic               tick;

   cfg_state_e         state_q;
   cfg_state_e         state_d;
   logic               cfg_ready;
   logic               accept;
   logic               apply;

   logic [2:0]         pend_ch_q;
   mode_e              pend_mode_q;
   logic [15:0]        pend_half_q;

   mode_e              mode_q  [NUM_LED];
   logic [15:0]        half_q  [NUM_LED];
   logic [15:0]        count_q [NUM_LED];
   logic [NUM_LED-1:0] led_q;
   logic [NUM_LED-1:0] done_q;
   logic [NUM_LED-1:0] at_end;
   logic [NUM_LED-1:0] hit;

   // Prescaler: free-running 0..COUNT_TO, tick decoded from the terminal count.
   always_ff @(posedge i_clk_100MHz or posedge i_rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values of the others.
      if (i_rst) begin
         presc_q <= '0;
      end else if (tick) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_q + 32'd1;
      end
   end

   assign tick = (presc_q == COUNT_TO);

   always_ff @(posedge i_clk_100MHz or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block is defaulted first so no path leaves
      // a signal unassigned and infers a latch.
      state_d   = state_q;
      cfg_ready = 1'b0;
      accept    = 1'b0;
      apply     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cfg_ready = 1'b1;
            if (cfg.valid) begin
               accept  = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
`ifdef LED_CTRL_IMMEDIATE_EN
            apply = 1'b1;
`else
            apply = tick;
`endif
            if (apply) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign cfg.ready = cfg_ready;

   // Pending request is only captured on acceptance, so a held valid cannot
   // overwrite it while waiting for the apply tick.
   always_ff @(posedge i_clk_100MHz or posedge i_rst) begin
      if (i_rst) begin
         pend_ch_q   <= '0;
         pend_mode_q <= MODE_OFF;
         pend_half_q <= '0;
      end else if (accept) begin
         pend_ch_q   <= cfg.ch;
         pend_mode_q <= mode_e'(cfg.mode);
         pend_half_q <= cfg.half;
      end
   end

   // Out-of-range channel numbers never match any index and are dropped here.
   always_comb begin
      at_end = '0;
      hit    = '0;
      for (int i = 0; i < NUM_LED; i++) begin
         at_end[i] = (count_q[i] == ((half_q[i] == 16'd0) ? 16'd0 : half_q[i] - 16'd1));
         hit[i]    = apply && (pend_ch_q == 3'(i));
      end
   end

   always_ff @(posedge i_clk_100MHz or posedge i_rst) begin
      if (i_rst) begin
         // NOTE: the per-channel arrays are small control state, so they are
         // reset explicitly rather than left uninitialised like a RAM.
         for (int i = 0; i < NUM_LED; i++) begin
            mode_q[i]  <= MODE_OFF;
            half_q[i]  <= '0;
            count_q[i] <= '0;
         end
         led_q  <= '0;
         done_q <= '0;
      end else begin
         done_q <= '0;
         for (int i = 0; i < NUM_LED; i++) begin
            if (hit[i]) begin
               // A write restarts the channel and overrides its own advance.
               mode_q[i]  <= pend_mode_q;
               half_q[i]  <= pend_half_q;
               count_q[i] <= '0;
               led_q[i]   <= (pend_mode_q != MODE_OFF);
            end else if (tick) begin
               case (mode_q[i])
                  MODE_OFF: begin
                     led_q[i]   <= 1'b0;
                     count_q[i] <= '0;
                  end
                  MODE_ON: begin
                     led_q[i]   <= 1'b1;
                     count_q[i] <= '0;
                  end
                  MODE_BLINK: begin
                     if (at_end[i]) begin
                        count_q[i] <= '0;
                        led_q[i]   <= ~led_q[i];
                     end else begin
                        count_q[i] <= count_q[i] + 16'd1;
                     end
                  end
                  MODE_ONESHOT: begin
                     if (at_end[i]) begin
                        count_q[i] <= '0;
                        led_q[i]   <= 1'b0;
                        mode_q[i]  <= MODE_OFF;
                        done_q[i]  <= 1'b1;
                     end else begin
                        count_q[i] <= count_q[i] + 16'd1;
                     end
                  end
                  default: begin
                     led_q[i]   <= 1'b0;
                     count_q[i] <= '0;
                  end
               endcase
            end
         end
      end
   end

   assign o_led  = led_q;
   assign o_done = done_q;
   assign o_tick = tick;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed bench for led_blink_ctrl at CLK_HZ=1000, TICK_HZ=100 (tick every 10 cycles).
// Outputs are sampled on the falling edge; "edges" counts rising edges since reset release.
module tb_led_blink_ctrl;
   localparam int NUM_LED = 4;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [NUM_LED-1:0] led;
   logic               tick;
   logic [NUM_LED-1:0] done;
   int                 edges = 0;
   int                 errors = 0;
   int                 checks = 0;

   led_blink_ctrl_if cfg_bus ();

   led_blink_ctrl #(
      .CLK_HZ  (1000),
      .TICK_HZ (100),
      .NUM_LED (NUM_LED)
   ) dut (
      .i_clk_100MHz (clk),
      .i_rst        (rst),
      .cfg          (cfg_bus),
      .o_led        (led),
      .o_tick       (tick),
      .o_done       (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) edges <= 0;
      else     edges <= edges + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edges);
      end
   endtask

   task automatic goto(input int n);
      while (edges < n) @(negedge clk);
   endtask

   task automatic request(input logic [2:0] ch, input logic [1:0] mode, input logic [15:0] half);
      cfg_bus.valid = 1'b1;
      cfg_bus.ch    = ch;
      cfg_bus.mode  = mode;
      cfg_bus.half  = half;
   endtask

   initial begin
      cfg_bus.valid = 1'b0;
      cfg_bus.ch    = '0;
      cfg_bus.mode  = '0;
      cfg_bus.half  = '0;

      @(negedge clk);
      check("rst_led", 32'(led), 32'h0);
      check("rst_tick", 32'(tick), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_ready", 32'(cfg_bus.ready), 32'h1);
      #2 rst = 1'b0;

      goto(8);  check("tick_pre", 32'(tick), 32'h0);
      goto(9);  check("tick_first", 32'(tick), 32'h1);
      goto(10); check("tick_post", 32'(tick), 32'h0);

`ifdef LED_CTRL_IMMEDIATE_EN
      goto(11); request(3'd0, 2'd1, 16'd0);
      goto(12); check("imm_ready_low", 32'(cfg_bus.ready), 32'h0);
                check("imm_led_wait", 32'(led), 32'h0);
                request(3'd0, 2'd2, 16'd1);
                cfg_bus.valid = 1'b0;
      goto(13); check("imm_ready_back", 32'(cfg_bus.ready), 32'h1);
                check("imm_led_on", 32'(led), 32'h1);
                request(3'd0, 2'd2, 16'd1);
      goto(14); check("imm_ready_low2", 32'(cfg_bus.ready), 32'h0);
                cfg_bus.valid = 1'b0;
      goto(15); check("imm_ready_back2", 32'(cfg_bus.ready), 32'h1);
                check("imm_blink_start", 32'(led), 32'h1);
      goto(19); check("imm_blink_hold", 32'(led), 32'h1);
                check("imm_tick", 32'(tick), 32'h1);
      goto(20); check("imm_blink_toggle", 32'(led), 32'h0);
`else
      // BLINK ch0 half=2: accepted at edge 11, applied at tick edge 20.
      request(3'd0, 2'd2, 16'd2);
      goto(11); check("blink_ready_low", 32'(cfg_bus.ready), 32'h0);
                cfg_bus.valid = 1'b0;
      goto(19); check("blink_led_before", 32'(led), 32'h0);
                check("blink_ready_wait", 32'(cfg_bus.ready), 32'h0);
      goto(20); check("blink_led_apply", 32'(led), 32'h1);
                check("blink_ready_back", 32'(cfg_bus.ready), 32'h1);
      goto(39); check("blink_hold", 32'(led), 32'h1);
      goto(40); check("blink_fall", 32'(led), 32'h0);
                request(3'd1, 2'd3, 16'd0);

      // ONESHOT ch1 half=0: lit from edge 50 to edge 60, done pulse at 60.
      goto(41); cfg_bus.valid = 1'b0;
      goto(49); check("os_before", 32'(led), 32'h0);
      goto(50); check("os_lit", 32'(led), 32'h2);
      goto(59); check("os_hold", 32'(led), 32'h2);
                check("os_no_done", 32'(done), 32'h0);
      goto(60); check("os_fall", 32'(led), 32'h1);
                check("os_done", 32'(done), 32'h2);
      goto(61); check("os_done_clear", 32'(done), 32'h0);

      // Back-to-back: ch2 ON then ch3 BLINK half=1 with valid held throughout.
                request(3'd2, 2'd1, 16'd0);
      goto(62); check("hs_ready_low", 32'(cfg_bus.ready), 32'h0);
                request(3'd3, 2'd2, 16'd1);
      goto(70); check("hs_first_apply", 32'(led), 32'h5);
                check("hs_ready_back", 32'(cfg_bus.ready), 32'h1);
      goto(71); check("hs_second_accept", 32'(cfg_bus.ready), 32'h0);
                cfg_bus.valid = 1'b0;
      goto(79); check("hs_second_wait", 32'(led), 32'h5);
      goto(80); check("hs_second_apply", 32'(led), 32'hC);
                check("hs_ready_back2", 32'(cfg_bus.ready), 32'h1);
      goto(90); check("os_stays_off", 32'(led), 32'h4);
      goto(100); check("run_100", 32'(led), 32'hD);

      // Restart ch0 with half=5; apply at edge 120 overrides its scheduled fall.
      goto(111); request(3'd0, 2'd2, 16'd5);
      goto(112); cfg_bus.valid = 1'b0;
      goto(120); check("restart_apply", 32'(led), 32'hD);

      // Out-of-range channel 6 with mode OFF: handshake completes, LEDs untouched.
      goto(121); request(3'd6, 2'd0, 16'd0);
      goto(122); check("oor_ready_low", 32'(cfg_bus.ready), 32'h0);
                 cfg_bus.valid = 1'b0;
      goto(130); check("oor_ready_back", 32'(cfg_bus.ready), 32'h1);
                 check("oor_led", 32'(led), 32'h5);
      goto(169); check("restart_hold", 32'(led), 32'hD);
      goto(170); check("restart_fall", 32'(led), 32'h4);
                 check("restart_no_done", 32'(done), 32'h0);

      // Reset mid-count with a request pending in WAIT.
      goto(171); request(3'd1, 2'd1, 16'd0);
      goto(172); check("pend_ready_low", 32'(cfg_bus.ready), 32'h0);
                 cfg_bus.valid = 1'b0;
      goto(173);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_led", 32'(led), 32'h0);
      check("mid_rst_tick", 32'(tick), 32'h0);
      check("mid_rst_done", 32'(done), 32'h0);
      check("mid_rst_ready", 32'(cfg_bus.ready), 32'h1);
      #1 rst = 1'b0;
      goto(1);  check("post_rst_ready", 32'(cfg_bus.ready), 32'h1);
      goto(8);  check("post_rst_tick_pre", 32'(tick), 32'h0);
      goto(9);  check("post_rst_tick", 32'(tick), 32'h1);
      goto(10); check("post_rst_discard", 32'(led), 32'h0);
                check("post_rst_ready2", 32'(cfg_bus.ready), 32'h1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
